// File: rtl/mi_if.sv
// Burst command / data bundle between an mi initiator (master) and a memory
// target (slave).
interface mi_if;
  logic [31:0] addr;
  logic [6:0]  len;
  logic        rw;
  logic        valid;
  logic        ready;
  logic [31:0] wdata;
  logic        wack;
  logic        wlast;
  logic [31:0] rdata;
  logic        rstb;
  logic        rlast;

  modport master (
    output addr, len, rw, valid, wdata,
    input  ready, wack, wlast, rdata, rstb, rlast
  );

  modport slave (
    input  addr, len, rw, valid, wdata,
    output ready, wack, wlast, rdata, rstb, rlast
  );
endinterface

// File: rtl/mi_bram_target.sv
// Zero-wait block-RAM target for the mi burst protocol: one burst at a time,
// one beat every BEAT_GAP+1 cycles, reads returned one cycle after issue.
module mi_bram_target #(
  parameter int AW       = 8,
  parameter int BEAT_GAP = 0
) (
  input  logic clk,
  input  logic rst_n,
  mi_if.slave  mi
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [3:0] GAP_RELOAD = 4'(BEAT_GAP);

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic [6:0]    cnt, cnt_next;
  logic [3:0]    gap, gap_next;
  logic          write_en, read_en;

  logic          ready, wack, wlast, rstb, rlast;
  logic [31:0]   rdata;
  logic [31:0]   ram [0:(1<<AW)-1];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    gap_next   = gap;
    write_en   = 1'b0;
    read_en    = 1'b0;
    case (state)
      IDLE: begin
        if (mi.valid && ready) begin
          ptr_next   = mi.addr[AW-1:0];
          cnt_next   = mi.len;
          gap_next   = 4'd0;
          state_next = mi.rw ? READ : WRITE;
        end
      end
      WRITE, READ: begin
        if (gap == 4'd0) begin
          write_en = (state == WRITE);
          read_en  = (state == READ);
          ptr_next = ptr + AW'(1);
          gap_next = GAP_RELOAD;
          if (cnt == 7'd0) state_next = (state == WRITE) ? IDLE : DRAIN;
          else             cnt_next   = cnt - 7'd1;
        end else begin
          gap_next = gap - 4'd1;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered, so wack is decided one cycle ahead from the next-state view.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gap   <= '0;
      ready <= 1'b0;
      wack  <= 1'b0;
      wlast <= 1'b0;
      rstb  <= 1'b0;
      rlast <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      gap   <= gap_next;
      ready <= (state_next == IDLE);
      wack  <= (state_next == WRITE) && (gap_next == 4'd0);
      wlast <= (state_next == WRITE) && (gap_next == 4'd0) && (cnt_next == 7'd0);
      rstb  <= read_en;
      rlast <= read_en && (cnt == 7'd0);
      if (read_en) rdata <= ram[ptr];
    end
  end

  // NOTE: the memory array has no reset so it maps onto block RAM and survives rst_n.
  always_ff @(posedge clk) begin
    if (write_en && rst_n) ram[ptr] <= mi.wdata;
  end

  assign mi.ready = ready;
  assign mi.wack  = wack;
  assign mi.wlast = wlast;
  assign mi.rstb  = rstb;
  assign mi.rlast = rlast;
  assign mi.rdata = rdata;

endmodule
